// File: rtl/rule_conf_sched_if.sv
// Request/write-port bundle for rule_conf_sched: requester handshake plus the
// 64-bit rule-write port towards the parser configuration block.
interface rule_conf_sched_if #(
  parameter int unsigned REQ_NUM  = 2,
  parameter int unsigned RULE_NUM = 4
) ();
  logic [REQ_NUM-1:0]          i_req_valid;
  logic [REQ_NUM-1:0]          i_req_is_rule;
  logic [REQ_NUM*RULE_NUM-1:0] i_req_mask;
  logic [REQ_NUM*256-1:0]      i_req_data;
  logic [REQ_NUM-1:0]          o_req_ready;
  logic                        o_rule_wren;
  logic [63:0]                 o_rule_wdata;
  logic [31:0]                 o_rule_addr;
  logic                        o_busy;

  modport master (
    output i_req_valid, i_req_is_rule, i_req_mask, i_req_data,
    input  o_req_ready, o_rule_wren, o_rule_wdata, o_rule_addr, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_is_rule, i_req_mask, i_req_data,
    output o_req_ready, o_rule_wren, o_rule_wdata, o_rule_addr, o_busy
  );
endinterface

// File: rtl/rule_conf_sched.sv
// Round-robin scheduler serializing rule / type-offset requests onto the config
// write port. Define RULE_CONF_SCHED_STATS_EN for grant/conflict counters.
module rule_conf_sched #(
  parameter int unsigned REQ_NUM    = 2,
  parameter int unsigned RULE_NUM   = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  rule_conf_sched_if.slave    bus
`ifdef RULE_CONF_SCHED_STATS_EN
  ,
  output logic [REQ_NUM*16-1:0] o_grant_cnt,
  output logic [15:0]           o_conflict_cnt
`endif
);

  localparam int unsigned PW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int unsigned GW = 4;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PW-1:0]       ptr;
  logic [1:0]          beat;
  logic [GW-1:0]       gap_cnt;
  logic                is_rule_q;
  logic [RULE_NUM-1:0] mask_q;
  logic [255:0]        data_q;

  logic                hi_found;
  logic                lo_found;
  logic [PW-1:0]       hi_idx;
  logic [PW-1:0]       lo_idx;
  logic                win_found;
  logic [PW-1:0]       win_idx;
  logic                grant;
  logic                last_beat;

  // Wrap-around search: first valid above the pointer, else lowest valid overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned j = 0; j < REQ_NUM; j++) begin
      if (bus.i_req_valid[j] && (j > 32'(ptr)) && !hi_found) begin
        hi_found = 1'b1;
        hi_idx   = PW'(j);
      end
      if (bus.i_req_valid[j] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = PW'(j);
      end
    end
    win_found = lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
  end

  // A request accepted while reset is asserted would be dropped, so no ready then.
  assign grant     = (state == IDLE) && win_found && !i_rst;
  assign last_beat = !is_rule_q || (beat == 2'd3);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      ptr       <= PW'(REQ_NUM - 1);
      beat      <= '0;
      gap_cnt   <= '0;
      is_rule_q <= 1'b0;
      mask_q    <= '0;
      data_q    <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        ptr       <= win_idx;
        beat      <= '0;
        is_rule_q <= bus.i_req_is_rule[win_idx];
        mask_q    <= bus.i_req_mask[32'(win_idx)*RULE_NUM +: RULE_NUM];
        data_q    <= bus.i_req_data[32'(win_idx)*256 +: 256];
      end else if (state == SEND) begin
        beat <= beat + 2'd1;
      end
      if (state == GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant) state_nxt = SEND;
      end
      SEND: begin
        if (last_beat) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.o_req_ready  = '0;
    bus.o_rule_wren  = 1'b0;
    bus.o_rule_wdata = '0;
    bus.o_rule_addr  = '0;
    bus.o_busy       = (state != IDLE);
    if (grant) bus.o_req_ready[win_idx] = 1'b1;
    if (state == SEND) begin
      bus.o_rule_wren = 1'b1;
      if (is_rule_q) begin
        bus.o_rule_wdata     = data_q[{beat, 6'd0} +: 64];
        bus.o_rule_addr[16]  = 1'b1;
        bus.o_rule_addr[9:8] = beat;
        // Commit bitmap only on the final beat, so an aborted rule commits nothing.
        if (beat == 2'd3) bus.o_rule_addr[RULE_NUM-1:0] = mask_q;
      end else begin
        bus.o_rule_wdata = data_q[63:0];
      end
    end
  end

`ifdef RULE_CONF_SCHED_STATS_EN
  logic [15:0] grant_cnt [REQ_NUM];
  logic [15:0] conflict_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned j = 0; j < REQ_NUM; j++) grant_cnt[j] <= '0;
      conflict_cnt <= '0;
    end else begin
      if (grant && (grant_cnt[win_idx] != '1)) begin
        grant_cnt[win_idx] <= grant_cnt[win_idx] + 16'd1;
      end
      if ((state == IDLE) && ($countones(bus.i_req_valid) >= 2) && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    o_grant_cnt = '0;
    for (int unsigned j = 0; j < REQ_NUM; j++) o_grant_cnt[j*16 +: 16] = grant_cnt[j];
    o_conflict_cnt = conflict_cnt;
  end
`endif

endmodule

// File: doc/rule_conf_sched.md
Name: rule_conf_sched

Overview:
Arbitrates between REQ_NUM configuration requesters (e.g. host register bridge, on-chip boot loader) that share the single 64-bit rule-write port of the parser configuration block.
- Each request carries a full 256-bit rule plus a target-rule bitmap, or a type-offset word.
- The block serializes a granted request into the beat sequence that port expects: rule beats with addr[16]=1 and addr[9:8]=beat index, commit bitmap in the low address bits on the last beat.
- Sits between the control-plane requesters and the parser configuration block.

Parameters:
REQ_NUM, 2, number of requesters (1..8)
RULE_NUM, 4, number of rule tables; width of commit bitmap (1..8, must not overlap addr[9:8])
GAP_CYCLES, 1, idle cycles inserted after each completed request (0..15)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_req_valid  in  REQ_NUM  per-requester request valid
i_req_is_rule  in  REQ_NUM  1=rule write (4 beats), 0=type-offset write (1 beat)
i_req_mask  in  REQ_NUM*RULE_NUM  per-requester target-rule bitmap
i_req_data  in  REQ_NUM*256  per-requester payload; type-offset uses [63:0] only
o_req_ready  out  REQ_NUM  one-cycle accept pulse, one-hot
o_rule_wren  out  1  write strobe to config block
o_rule_wdata  out  64  write data
o_rule_addr  out  32  write address
o_busy  out  1  high from grant until end of gap

Behaviour:
- Reset: all outputs 0; state=IDLE; round-robin pointer=REQ_NUM-1, so requester 0 wins first; internal payload register cleared.
- States: IDLE, SEND, GAP.
- IDLE arbitration:
  - Requests with valid=1 arbitrate round-robin, searching from pointer+1 upward with wrap.
  - Winner gets o_req_ready=1 in that cycle.
  - On the same edge, is_rule, mask and data are captured, the pointer is set to the winner, and the state goes to SEND with beat counter 0.
- Requester handshake: a requester must hold valid and payload stable until it sees ready. Deasserting valid before ready withdraws the request; this is legal.
- SEND, rule request, 4 consecutive cycles, k=0..3:
  - o_rule_wren=1.
  - o_rule_wdata=payload[64k+:64].
  - o_rule_addr: bit16=1, bits[9:8]=k, bits[RULE_NUM-1:0]=mask on k=3 only (0 on k<3), all other bits 0.
- SEND, type-offset request, 1 cycle:
  - o_rule_wren=1, o_rule_wdata=payload[63:0], o_rule_addr=0.
- Latency: first beat appears in the cycle after the ready pulse.
- After the last beat:
  - GAP_CYCLES>0: go to GAP for GAP_CYCLES cycles, then IDLE.
  - GAP_CYCLES=0: go directly to IDLE.
- Back-to-back throughput:
  - Arbitration happens only in IDLE; there is no ready pulse in SEND or GAP.
  - Minimum request spacing is beats+GAP_CYCLES+1 cycles.
- o_rule_wren is 0 in IDLE and GAP.
- o_busy is 1 in SEND and GAP, 0 in IDLE.
- Zero mask on a rule request: all 4 beats are issued with bitmap 0. The config block loads its buffer but commits nothing; this is legal.
- Single requester: REQ_NUM=1 degenerates to pass-through sequencing; pointer logic is a constant.
- Reset mid-SEND: the next edge forces IDLE and wren=0. Because the commit bitmap appears only on beat 3, no table receives a partial rule. The interrupted requester has already seen ready and must re-issue.
- Simultaneous valid from all requesters: each is granted exactly once per REQ_NUM grants, in strictly rotating order.

Optional Feature:
RULE_CONF_SCHED_STATS_EN
- Defined:
  - Adds output o_grant_cnt, REQ_NUM*16 bits: per-requester saturating grant counters, held at 16'hFFFF once reached.
  - Adds output o_conflict_cnt, 16 bits, saturating: counts IDLE cycles where 2 or more requests were valid.
  - All counters clear on i_rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Single rule, req0: data={64'h4,64'h3,64'h2,64'h1}, mask=4'b0101 → ready0 for 1 cycle; next 4 cycles wren=1 with:
   - wdata 1,2,3,4
   - addr 32'h10000, 32'h10100, 32'h10200, 32'h10305
   - then 1 gap cycle, busy=0.
2. Type-offset, req1: data[63:0]=64'h0000_0000_0A1E_2814 → one beat: wren=1, addr=0, wdata=64'hA1E2814; busy high for 2 cycles total.
3. Both requesters valid continuously with rule requests (REQ_NUM=2, GAP=1) → grants alternate 0,1,0,1; ready pulses exactly 6 cycles apart; no overlapping beats.
4. Assert i_rst during beat 2 of a rule with mask 4'b1111 → next cycle wren=0, busy=0; no beat with nonzero addr[3:0] was ever issued; the following request starts at beat 0.
5. Valid withdrawn: req0 valid for 1 cycle while the block is in SEND for req1, then dropped → req0 never sees ready and no beats are issued for it.
6. STATS_EN defined, 3 grants to req0 plus 2 conflict cycles → o_grant_cnt[0]=3, o_conflict_cnt=2; preload near 16'hFFFF → holds at 16'hFFFF.
